reg_scoreboard: RTL and testbench

//  Tracks in-flight register writes between the decode stage and write-back. Replaces
//  the per-stage EX/MEM address compare with per-register pending counters.

---
 rtl/reg_scoreboard.sv | 107 ++++++++++
 tb/tb_reg_scoreboard.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters between decode and write-back.
// Raises a combinational stall on RAW hazards or when a destination's counter is saturated.
module reg_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int CNT_W     = 2,
  parameter bit BYPASS_WB = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid_i,
  input  logic                rs1_read_i,
  input  logic [4:0]          rs1_addr_i,
  input  logic                rs2_read_i,
  input  logic [4:0]          rs2_addr_i,
  input  logic                wreg_i,
  input  logic [4:0]          wd_i,
  input  logic                wb_valid_i,
  input  logic [4:0]          wb_addr_i,
  input  logic                flush_i,
  output logic                stall_req_o,
  output logic                issue_fire_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [5:0]          inflight_o,
  output logic                err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic [5:0]       inflight_q, inflight_d;
  logic             err_q, err_d;

  logic rs1_blk, rs2_blk, dst_full, stall, fire;
  logic inc_any, dec_any, wb_orphan;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rs1_blk = rs1_read_i && (rs1_addr_i != '0) && (cnt_q[rs1_addr_i] != '0);
    if (BYPASS_WB && (cnt_q[rs1_addr_i] == CNT_ONE) && wb_valid_i && (wb_addr_i == rs1_addr_i))
      rs1_blk = 1'b0;

    rs2_blk = rs2_read_i && (rs2_addr_i != '0) && (cnt_q[rs2_addr_i] != '0);
    if (BYPASS_WB && (cnt_q[rs2_addr_i] == CNT_ONE) && wb_valid_i && (wb_addr_i == rs2_addr_i))
      rs2_blk = 1'b0;

    // A write-back in the same cycle does not free a saturated destination.
    dst_full  = wreg_i && (wd_i != '0) && (cnt_q[wd_i] == CNT_MAX);
    stall     = issue_valid_i && (rs1_blk || rs2_blk || dst_full);
    fire      = rst && issue_valid_i && !stall && !flush_i;

    inc_any   = fire && wreg_i && (wd_i != '0);
    dec_any   = wb_valid_i && (wb_addr_i != '0) && (cnt_q[wb_addr_i] != '0);
    wb_orphan = wb_valid_i && (wb_addr_i != '0) && (cnt_q[wb_addr_i] == '0);
  end

  always_comb begin
    cnt_d[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush_i)
        cnt_d[r] = '0;
      else if (inc_any && (wd_i == 5'(r)) && !(dec_any && (wb_addr_i == 5'(r))))
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      else if (dec_any && (wb_addr_i == 5'(r)) && !(inc_any && (wd_i == 5'(r))))
        cnt_d[r] = cnt_q[r] - CNT_ONE;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (flush_i)
      inflight_d = '0;
    else if (inc_any && !dec_any && (inflight_q != 6'd63))
      inflight_d = inflight_q + 6'd1;
    else if (dec_any && !inc_any && (inflight_q != 6'd0))
      inflight_d = inflight_q - 6'd1;

    err_d = err_q || (wb_orphan && !flush_i);
  end

  // NOTE: the counter array is a bank of flops, not a RAM, so it is reset like any other state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int r = 1; r < NUM_REGS; r++) busy_o[r] = (cnt_q[r] != '0);
  end

  assign stall_req_o  = stall;
  assign issue_fire_o = fire;
  assign inflight_o   = inflight_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed hazard scenarios, then random traffic
// compared against an integer-counter reference model.
module tb_reg_scoreboard;

  localparam int NR   = 32;
  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid_i = 1'b0, rs1_read_i = 1'b0, rs2_read_i = 1'b0, wreg_i = 1'b0;
  logic [4:0]  rs1_addr_i = '0, rs2_addr_i = '0, wd_i = '0, wb_addr_i = '0;
  logic        wb_valid_i = 1'b0, flush_i = 1'b0;
  logic        stall_req_o, issue_fire_o, err_o;
  logic [31:0] busy_o;
  logic [5:0]  inflight_o;

  int cnt [NR];
  bit m_err;
  int m_infl;
  int n_chk  = 0;
  int n_fail = 0;

  reg_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(issue_valid_i),
    .rs1_read_i(rs1_read_i), .rs1_addr_i(rs1_addr_i),
    .rs2_read_i(rs2_read_i), .rs2_addr_i(rs2_addr_i),
    .wreg_i(wreg_i), .wd_i(wd_i),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i),
    .flush_i(flush_i),
    .stall_req_o(stall_req_o), .issue_fire_o(issue_fire_o),
    .busy_o(busy_o), .inflight_o(inflight_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_blk(input bit rd, input int a);
    if (!rd || a == 0 || cnt[a] == 0) return 1'b0;
    if (cnt[a] == 1 && wb_valid_i && int'(wb_addr_i) == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    bit full;
    full = wreg_i && wd_i != 0 && cnt[wd_i] == MAXC;
    return issue_valid_i && (m_blk(rs1_read_i, rs1_addr_i) || m_blk(rs2_read_i, rs2_addr_i) || full);
  endfunction

  function automatic bit m_fire();
    return issue_valid_i && !m_stall() && !flush_i;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < NR; r++) b[r] = (cnt[r] != 0);
    return b;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NR; r++) cnt[r] = 0;
    m_infl = 0;
    m_err  = 1'b0;
  endtask

  // Applies one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    int delta;
    bit fire;
    fire  = m_fire();
    delta = 0;
    if (flush_i) begin
      for (int r = 0; r < NR; r++) cnt[r] = 0;
      m_infl = 0;
    end else begin
      if (wb_valid_i && wb_addr_i != 0) begin
        if (cnt[wb_addr_i] == 0) m_err = 1'b1;
        else begin cnt[wb_addr_i]--; delta--; end
      end
      if (fire && wreg_i && wd_i != 0) begin cnt[wd_i]++; delta++; end
      m_infl += delta;
      if (m_infl > 63) m_infl = 63;
      if (m_infl < 0)  m_infl = 0;
    end
  endtask

  task automatic drive(input bit iv, input bit r1rd, input int r1, input bit r2rd, input int r2,
                       input bit wr, input int wd, input bit wbv, input int wba, input bit fl);
    issue_valid_i = iv;
    rs1_read_i = r1rd; rs1_addr_i = 5'(r1);
    rs2_read_i = r2rd; rs2_addr_i = 5'(r2);
    wreg_i = wr; wd_i = 5'(wd);
    wb_valid_i = wbv; wb_addr_i = 5'(wba);
    flush_i = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after a falling edge with inputs driven; compares, then advances one cycle.
  task automatic cyc(input string tag);
    #1;
    check({tag, "_stall"},    32'(stall_req_o),  32'(m_stall()));
    check({tag, "_fire"},     32'(issue_fire_o), 32'(m_fire()));
    check({tag, "_busy"},     busy_o,            m_busy());
    check({tag, "_inflight"}, 32'(inflight_o),   32'(m_infl));
    check({tag, "_err"},      32'(err_o),        32'(m_err));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    model_clear();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    @(negedge clk);
    #1;
    check("rst_fire",     32'(issue_fire_o), 32'd0);
    check("rst_stall",    32'(stall_req_o),  32'd0);
    check("rst_busy",     busy_o,            32'd0);
    check("rst_inflight", 32'(inflight_o),   32'd0);
    check("rst_err",      32'(err_o),        32'd0);
    @(negedge clk);
    rst = 1'b1;

    // T1: RAW on x5, released by a same-cycle write-back
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    #1 check("t1_fire0", 32'(issue_fire_o), 32'd1);
    cyc("t1_c0");
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t1_stall1", 32'(stall_req_o), 32'd1);
    check("t1_busy5", 32'(busy_o[5]), 32'd1);
    cyc("t1_c1");
    cyc("t1_c2");
    drive(1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
    #1 check("t1_stall3", 32'(stall_req_o), 32'd0);
    check("t1_fire3", 32'(issue_fire_o), 32'd1);
    cyc("t1_c3");
    idle();
    #1 check("t1_busy5_c4", 32'(busy_o[5]), 32'd0);
    cyc("t1_c4");

    // T2: saturate x7, fourth write stalls even with a matching write-back
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
      cyc("t2_w");
    end
    drive(1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
    #1 check("t2_full_stall", 32'(stall_req_o), 32'd1);
    cyc("t2_full");
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    #1 check("t2_fourth_fire", 32'(issue_fire_o), 32'd1);
    cyc("t2_fourth");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
      #1 check("t2_busy7_held", 32'(busy_o[7]), 32'd1);
      cyc("t2_wb");
    end
    idle();
    #1 check("t2_busy7_clear", 32'(busy_o[7]), 32'd0);
    check("t2_inflight0", 32'(inflight_o), 32'd0);
    cyc("t2_end");

    // T3: simultaneous issue and write-back to x9 holds its counter
    drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    cyc("t3_a");
    drive(1, 0, 0, 0, 0, 1, 9, 1, 9, 0);
    cyc("t3_b");
    idle();
    #1 check("t3_inflight", 32'(inflight_o), 32'd1);
    check("t3_busy9", 32'(busy_o[9]), 32'd1);
    cyc("t3_c");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    cyc("t3_drain");

    // T4: x0 is invisible; orphan write-back sets the sticky error
    drive(1, 1, 0, 1, 0, 1, 0, 1, 0, 0);
    #1 check("t4_x0_stall", 32'(stall_req_o), 32'd0);
    cyc("t4_x0");
    idle();
    #1 check("t4_inflight", 32'(inflight_o), 32'd0);
    cyc("t4_idle");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    cyc("t4_orphan");
    idle();
    #1 check("t4_err", 32'(err_o), 32'd1);
    check("t4_busy", busy_o, 32'd0);
    cyc("t4_after");

    // T5: flush with a pending issue
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 0); cyc("t5_w4");
    drive(1, 0, 0, 0, 0, 1, 6, 0, 0, 0); cyc("t5_w6");
    drive(1, 0, 0, 0, 0, 1, 8, 0, 0, 0); cyc("t5_w8");
    drive(1, 0, 0, 0, 0, 1, 10, 1, 4, 1);
    #1 check("t5_flush_fire", 32'(issue_fire_o), 32'd0);
    cyc("t5_flush");
    idle();
    #1 check("t5_busy", busy_o, 32'd0);
    check("t5_inflight", 32'(inflight_o), 32'd0);
    check("t5_err_kept", 32'(err_o), 32'd1);
    cyc("t5_after");

    // T6: asynchronous reset while a hazard is stalling
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0, 0); cyc("t6_w4");
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t6_pre_stall", 32'(stall_req_o), 32'd1);
    #1 rst = 1'b0;
    #1 check("t6_busy", busy_o, 32'd0);
    check("t6_stall", 32'(stall_req_o), 32'd0);
    check("t6_err", 32'(err_o), 32'd0);
    check("t6_inflight", 32'(inflight_o), 32'd0);
    model_clear();
    idle();
    @(negedge clk);
    rst = 1'b1;

    // Random traffic over a small register window to provoke hazards
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 39) == 0);
      cyc("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
